// File: rtl/spi_bridge_pkg.sv
// Shared command/state encodings for the SPI-to-RAM bridge.
package spi_bridge_pkg;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        RD_DATA,
        DONE
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_bridge_ram.sv
// Synchronous single-port RAM, read-first, one-cycle registered read, no reset.
module spi_bridge_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            rdata_q <= mem_q[addr_i];
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_ram_bridge.sv
// Bit-serial SPI slave giving a host burst read/write access to an on-chip RAM.
module spi_ram_bridge
    import spi_bridge_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 256,
    parameter int BURST_EN = 1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic busy,
    output logic wr_stb
);

    localparam int RX_W  = max_int(DATA_W, ADDR_W);
    localparam int CNT_W = $clog2(RX_W);
    localparam logic [CNT_W-1:0] DATA_LAST   = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] PREFETCH_AT = CNT_W'(DATA_W - 2);
    localparam logic [CNT_W-1:0] ADDR_LAST   = CNT_W'(ADDR_W - 1);

    state_t            state_q, state_d;
    logic              cmd_hi_q, cmd_hi_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RX_W-2:0]   rx_q, rx_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              wr_stb_q, wr_stb_d;

    logic [RX_W-1:0]   rx_shift;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    assign rx_shift = {rx_q, MOSI};

    always_comb begin
        state_d   = state_q;
        cmd_hi_d  = cmd_hi_q;
        cnt_d     = cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        wr_stb_d  = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = rd_addr_q;

        // Deselect aborts any frame; partial words are simply dropped.
        if (SS_n) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cmd_hi_d = MOSI;
                    state_d  = CMD;
                end
                CMD: begin
                    cnt_d = '0;
                    case (cmd_t'({cmd_hi_q, MOSI}))
                        CMD_WR_ADDR: state_d = WR_ADDR;
                        CMD_WR_DATA: state_d = WR_DATA;
                        CMD_RD_ADDR: state_d = RD_ADDR;
                        CMD_RD_DATA: state_d = RD_WAIT;
                        default:     state_d = DONE;
                    endcase
                end
                WR_ADDR, RD_ADDR: begin
                    rx_d  = rx_shift[RX_W-2:0];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == ADDR_LAST) begin
                        if (state_q == WR_ADDR) begin
                            wr_addr_d = rx_shift[ADDR_W-1:0];
                        end else begin
                            rd_addr_d = rx_shift[ADDR_W-1:0];
                        end
                        cnt_d   = '0;
                        state_d = DONE;
                    end
                end
                WR_DATA: begin
                    rx_d  = rx_shift[RX_W-2:0];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == DATA_LAST) begin
                        ram_en    = 1'b1;
                        ram_we    = 1'b1;
                        ram_addr  = wr_addr_q;
                        wr_stb_d  = 1'b1;
                        wr_addr_d = wr_addr_q + 1'b1;
                        cnt_d     = '0;
                        if (BURST_EN == 0) begin
                            state_d = DONE;
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == '0) begin
                        ram_en = 1'b1;
                        cnt_d  = CNT_W'(1);
                    end else begin
                        tx_d      = ram_rdata;
                        rd_addr_d = rd_addr_q + 1'b1;
                        cnt_d     = '0;
                        state_d   = RD_DATA;
                    end
                end
                RD_DATA: begin
                    tx_d  = {tx_q[DATA_W-2:0], 1'b0};
                    cnt_d = cnt_q + 1'b1;
                    // Fetch the next word one bit early so a burst has no gap.
                    if (cnt_q == PREFETCH_AT) begin
                        ram_en = 1'b1;
                    end
                    if (cnt_q == DATA_LAST) begin
                        cnt_d = '0;
                        if (BURST_EN != 0) begin
                            tx_d      = ram_rdata;
                            rd_addr_d = rd_addr_q + 1'b1;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cmd_hi_q  <= 1'b0;
            cnt_q     <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            wr_stb_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_hi_q  <= cmd_hi_d;
            cnt_q     <= cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            wr_stb_q  <= wr_stb_d;
        end
    end

    spi_bridge_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_en && !rst),
        .we_i    (ram_we && !rst),
        .addr_i  (ram_addr),
        .wdata_i (rx_shift[DATA_W-1:0]),
        .rdata_o (ram_rdata)
    );

    assign MISO   = (state_q == RD_DATA) && tx_q[DATA_W-1];
    assign busy   = (state_q != IDLE);
    assign wr_stb = wr_stb_q;

endmodule
